// File: rtl/controls_pkg.sv
// Shared move-command encoding for the button front end and the game logic that consumes it.
package controls_pkg;

    localparam int MOVE_W = 2;

    localparam logic [MOVE_W-1:0] MOVE_UP   = 2'd0;
    localparam logic [MOVE_W-1:0] MOVE_DOWN = 2'd1;
    localparam logic [MOVE_W-1:0] MOVE_NONE = 2'd2;

    // Exactly one key pressed selects its direction; none or both is neutral.
    function automatic logic [MOVE_W-1:0] decode_move(input logic up, input logic down);
        logic [MOVE_W-1:0] m;
        m = MOVE_NONE;
        if (up && !down)
            m = MOVE_UP;
        else if (!up && down)
            m = MOVE_DOWN;
        return m;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key synchroniser followed by a consecutive-mismatch debounce filter.
module key_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_db
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;

    always_ff @(posedge clk) begin
        if (rst)
            sync <= '0;
        else
            sync <= {sync[SYNC_STAGES-2:0], key_raw};
    end

    assign synced = sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign key_db = synced;
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          db;

            // cnt tracks how long synced has disagreed with db; any agreement restarts it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt <= '0;
                    db  <= 1'b0;
                end else if (synced == db) begin
                    cnt <= '0;
                end else if (cnt == TC) begin
                    db  <= synced;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign key_db = db;
        end
    endgenerate

endmodule

// File: rtl/controls.sv
// Button front end: two debounced keys decoded into a registered move command.
module controls
    import controls_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_up,
    input  logic              key_down,
    output logic [MOVE_W-1:0] move
);

    logic up_db;
    logic down_db;

    key_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_up (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_up),
        .key_db  (up_db)
    );

    key_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_down (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_down),
        .key_db  (down_db)
    );

    always_ff @(posedge clk) begin
        if (rst)
            move <= MOVE_NONE;
        else
            move <= decode_move(up_db, down_db);
    end

endmodule

// File: tb/tb_controls.sv
// Randomized and directed checks of controls (default and zero-debounce builds) against a window model.
module tb_controls;

    localparam int S = 2;
    localparam int NDB [2] = '{4, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic [1:0] move;
    logic [1:0] move_fast;

    int total = 0;
    int bad   = 0;

    controls #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .move(move)
    );

    controls #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut_fast (
        .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .move(move_fast)
    );

    always #5 clk = ~clk;

    // Model: raw history per key, and per build a window of the last N synced values.
    bit raw_q [2][$];
    bit win   [2][2][$];
    bit db_m  [2][2];
    int mv_m  [2];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int dec(input bit up, input bit dn);
        if (up && !dn) return 0;
        if (!up && dn) return 1;
        return 2;
    endfunction

    task automatic model_edge(input bit r, input bit u, input bit d);
        bit sv [2];
        bit all_diff;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                raw_q[k].delete();
                for (int j = 0; j < S; j++) raw_q[k].push_back(1'b0);
            end
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 2; k++) begin
                    win[i][k].delete();
                    db_m[i][k] = 1'b0;
                end
                mv_m[i] = 2;
            end
        end else begin
            sv[0] = raw_q[0].pop_front();
            sv[1] = raw_q[1].pop_front();
            raw_q[0].push_back(u);
            raw_q[1].push_back(d);
            for (int i = 0; i < 2; i++) begin
                if (NDB[i] == 0) begin
                    mv_m[i] = dec(sv[0], sv[1]);
                end else begin
                    mv_m[i] = dec(db_m[i][0], db_m[i][1]);
                    for (int k = 0; k < 2; k++) begin
                        win[i][k].push_back(sv[k]);
                        if (win[i][k].size() > NDB[i]) void'(win[i][k].pop_front());
                        all_diff = (win[i][k].size() == NDB[i]);
                        foreach (win[i][k][j]) if (win[i][k][j] == db_m[i][k]) all_diff = 1'b0;
                        if (all_diff) db_m[i][k] = sv[k];
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit u, input bit d);
        @(negedge clk);
        rst = r;
        key_up = u;
        key_down = d;
        @(posedge clk);
        model_edge(r, u, d);
        #1;
        chk("move", int'(move), mv_m[0]);
        chk("move_fast", int'(move_fast), mv_m[1]);
    endtask

    // Hold keys for a bounded number of edges; record the first edge each build shows want.
    task automatic hold_lat(input bit u, input bit d, input int want, output int l0, output int l1);
        l0 = -1;
        l1 = -1;
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, u, d);
            if (l0 < 0 && int'(move) == want) l0 = k;
            if (l1 < 0 && int'(move_fast) == want) l1 = k;
        end
    endtask

    // Drive a pulse of len cycles on key_up, then count edges each build reports UP.
    task automatic pulse(input int len, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, k < len, 1'b0);
            if (move == 2'd0) c0++;
            if (move_fast == 2'd0) c1++;
        end
    endtask

    initial begin
        int l0, l1, c0, c1, nz;
        int hold_u, hold_d;
        bit ru, rd;

        // Reset with key_up held, then release.
        step(1'b1, 1'b1, 1'b0);
        chk("rst_move", int'(move), 2);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_move2", int'(move_fast), 2);
        hold_lat(1'b1, 1'b0, 0, l0, l1);
        chk("rst_lat", l0, 7);
        chk("rst_lat_fast", l1, 3);

        hold_lat(1'b0, 1'b0, 2, l0, l1);
        chk("release_lat", l0, 7);
        chk("release_lat_fast", l1, 3);

        hold_lat(1'b0, 1'b1, 1, l0, l1);
        chk("down_lat", l0, 7);
        chk("down_lat_fast", l1, 3);
        hold_lat(1'b0, 1'b0, 2, l0, l1);
        chk("down_release_lat", l0, 7);

        // Simultaneous press stays neutral.
        nz = 0;
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b1, 1'b1);
            if (move != 2'd2 || move_fast != 2'd2) nz++;
        end
        chk("both_neutral", nz, 0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);

        // From steady UP, adding DOWN returns to neutral.
        hold_lat(1'b1, 1'b0, 0, l0, l1);
        hold_lat(1'b1, 1'b1, 2, l0, l1);
        chk("up_plus_down_lat", l0, 7);
        chk("up_plus_down_lat_fast", l1, 3);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);

        pulse(3, c0, c1);
        chk("glitch3", c0, 0);
        chk("glitch3_fast", c1, 3);
        pulse(4, c0, c1);
        chk("pulse4", c0, 4);
        chk("pulse4_fast", c1, 4);

        // Reset in the middle of a steady press.
        hold_lat(1'b1, 1'b0, 0, l0, l1);
        step(1'b1, 1'b1, 1'b0);
        chk("midpress_rst", int'(move), 2);
        chk("midpress_rst_fast", int'(move_fast), 2);
        hold_lat(1'b1, 1'b0, 0, l0, l1);
        chk("midpress_lat", l0, 7);
        chk("midpress_lat_fast", l1, 3);

        // Random key activity with occasional resets.
        hold_u = 0;
        hold_d = 0;
        ru = 1'b0;
        rd = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (hold_u == 0) begin
                ru = $urandom_range(0, 1);
                hold_u = $urandom_range(1, 9);
            end
            if (hold_d == 0) begin
                rd = $urandom_range(0, 1);
                hold_d = $urandom_range(1, 9);
            end
            hold_u--;
            hold_d--;
            step($urandom_range(0, 199) == 0, ru, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
